// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared widths and the EX/MEM control bundle for the MIPS pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int DATA_W      = 32;
    localparam int REG_AW      = 5;
    localparam int FLUSH_CNT_W = 3;

    typedef struct packed {
        logic valid;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } ctrl_t;

    localparam ctrl_t c_ctrl_bubble = '0;

endpackage

`default_nettype wire

// File: rtl/ex_mem_stage_flush_timer.sv
// ============================================================================
// Module   : flush_timer
// Brief    : IDLE/FLUSH FSM holding flush_o high for FLUSH_CYCLES after a start.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flush_timer #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start,
    output logic flush_o
);
    import cpu_pkg::*;

    localparam logic [0:0] c_s_idle  = 1'b0;
    localparam logic [0:0] c_s_flush = 1'b1;

    localparam logic [FLUSH_CNT_W-1:0] c_cnt_init = FLUSH_CNT_W'(FLUSH_CYCLES);
    localparam logic [FLUSH_CNT_W-1:0] c_cnt_one  = FLUSH_CNT_W'(1);

    logic [0:0]             r_state;
    logic [FLUSH_CNT_W-1:0] r_cnt;

    // The counter runs regardless of stall so the squash window is fixed.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= c_s_idle;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_s_idle: begin
                    if (start) begin
                        r_state <= c_s_flush;
                        r_cnt   <= c_cnt_init;
                    end
                end
                c_s_flush: begin
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_state <= c_s_idle;
                    end
                end
                default: r_state <= c_s_idle;
            endcase
        end
    end

    assign flush_o = (r_state == c_s_flush);

endmodule

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module   : ex_mem_stage
// Brief    : EX/MEM pipeline register with beq/bne resolution and flush control.
//            Optional forwarding outputs enabled by macro EXMEM_FWD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_stage #(
    parameter int DATA_W       = cpu_pkg::DATA_W,
    parameter int REG_AW       = cpu_pkg::REG_AW,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              ex_valid_i,
    input  logic [DATA_W-1:0] ex_alu_out_i,
    input  logic              ex_zero_i,
    input  logic [DATA_W-1:0] ex_rt_data_i,
    input  logic [REG_AW-1:0] ex_wreg_i,
    input  logic [DATA_W-1:0] ex_br_target_i,
    input  logic              ex_branch_i,
    input  logic              ex_branch_ne_i,
    input  logic              ex_mem_read_i,
    input  logic              ex_mem_write_i,
    input  logic              ex_reg_write_i,
    input  logic              ex_mem_to_reg_i,
    output logic              mem_valid_o,
    output logic [DATA_W-1:0] mem_alu_out_o,
    output logic [DATA_W-1:0] mem_rt_data_o,
    output logic [REG_AW-1:0] mem_wreg_o,
    output logic              mem_mem_read_o,
    output logic              mem_mem_write_o,
    output logic              mem_reg_write_o,
    output logic              mem_mem_to_reg_o,
    output logic              pc_src_o,
    output logic [DATA_W-1:0] br_target_o,
    output logic              flush_o
`ifdef EXMEM_FWD_EN
    ,
    output logic              fwd_valid_o,
    output logic [REG_AW-1:0] fwd_reg_o,
    output logic [DATA_W-1:0] fwd_data_o
`endif
);
    import cpu_pkg::*;

    ctrl_t             w_ex_ctrl;
    ctrl_t             r_ctrl;
    logic              w_flush;
    logic              w_taken;
    logic              w_start;
    logic [DATA_W-1:0] r_alu_out;
    logic [DATA_W-1:0] r_rt_data;
    logic [REG_AW-1:0] r_wreg;
    logic              r_pc_src;
    logic [DATA_W-1:0] r_br_target;

    // Controls of a bubble must never reach memory or the register file.
    assign w_ex_ctrl = '{valid:      ex_valid_i,
                         mem_read:   ex_mem_read_i   & ex_valid_i,
                         mem_write:  ex_mem_write_i  & ex_valid_i,
                         reg_write:  ex_reg_write_i  & ex_valid_i,
                         mem_to_reg: ex_mem_to_reg_i & ex_valid_i};

    assign w_taken = ex_valid_i & ex_branch_i & (ex_zero_i ^ ex_branch_ne_i) & ~w_flush;
    assign w_start = w_taken & ~stall_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ctrl      <= c_ctrl_bubble;
            r_alu_out   <= '0;
            r_rt_data   <= '0;
            r_wreg      <= '0;
            r_pc_src    <= 1'b0;
            r_br_target <= '0;
        end else if (w_flush) begin
            r_ctrl   <= c_ctrl_bubble;
            r_pc_src <= 1'b0;
        end else if (!stall_i) begin
            r_ctrl    <= w_ex_ctrl;
            r_alu_out <= ex_alu_out_i;
            r_rt_data <= ex_rt_data_i;
            r_wreg    <= ex_wreg_i;
            r_pc_src  <= w_taken;
            if (w_taken) begin
                r_br_target <= ex_br_target_i;
            end
        end
    end

    flush_timer #(
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_flush_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start   (w_start),
        .flush_o (w_flush)
    );

    assign mem_valid_o      = r_ctrl.valid;
    assign mem_mem_read_o   = r_ctrl.mem_read;
    assign mem_mem_write_o  = r_ctrl.mem_write;
    assign mem_reg_write_o  = r_ctrl.reg_write;
    assign mem_mem_to_reg_o = r_ctrl.mem_to_reg;
    assign mem_alu_out_o    = r_alu_out;
    assign mem_rt_data_o    = r_rt_data;
    assign mem_wreg_o       = r_wreg;
    assign pc_src_o         = r_pc_src;
    assign br_target_o      = r_br_target;
    assign flush_o          = w_flush;

`ifdef EXMEM_FWD_EN
    // Loads are excluded: their data only exists after the memory access.
    assign fwd_valid_o = r_ctrl.valid & r_ctrl.reg_write & ~r_ctrl.mem_to_reg
                       & (r_wreg != '0);
    assign fwd_reg_o   = r_wreg;
    assign fwd_data_o  = r_alu_out;
`else
    // No forwarding path from this stage.
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// ============================================================================
// Module   : tb_ex_mem_stage
// Brief    : Directed + randomized checks of ex_mem_stage against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_stage;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int FC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall, ev, zero, br, ne, mr, mw, rw, m2r;
    logic [DW-1:0] alu, rt, tgt;
    logic [AW-1:0] wreg;

    logic          o_valid, o_mr, o_mw, o_rw, o_m2r, o_pcsrc, o_flush;
    logic [DW-1:0] o_alu, o_rt, o_tgt;
    logic [AW-1:0] o_wreg;
`ifdef EXMEM_FWD_EN
    logic          o_fv;
    logic [AW-1:0] o_freg;
    logic [DW-1:0] o_fdata;
`endif

    always #5 clk = ~clk;

    ex_mem_stage #(.DATA_W(DW), .REG_AW(AW), .FLUSH_CYCLES(FC)) dut (
        .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .ex_valid_i(ev),
        .ex_alu_out_i(alu), .ex_zero_i(zero), .ex_rt_data_i(rt), .ex_wreg_i(wreg),
        .ex_br_target_i(tgt), .ex_branch_i(br), .ex_branch_ne_i(ne),
        .ex_mem_read_i(mr), .ex_mem_write_i(mw), .ex_reg_write_i(rw),
        .ex_mem_to_reg_i(m2r), .mem_valid_o(o_valid), .mem_alu_out_o(o_alu),
        .mem_rt_data_o(o_rt), .mem_wreg_o(o_wreg), .mem_mem_read_o(o_mr),
        .mem_mem_write_o(o_mw), .mem_reg_write_o(o_rw), .mem_mem_to_reg_o(o_m2r),
        .pc_src_o(o_pcsrc), .br_target_o(o_tgt), .flush_o(o_flush)
`ifdef EXMEM_FWD_EN
        , .fwd_valid_o(o_fv), .fwd_reg_o(o_freg), .fwd_data_o(o_fdata)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what MEM should hold, plus cycles of squash remaining.
    logic          m_valid, m_mr, m_mw, m_rw, m_m2r, m_pcsrc;
    logic [DW-1:0] m_alu, m_rt, m_tgt;
    logic [AW-1:0] m_wreg;
    int            m_frem;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_m2r = 0; m_pcsrc = 0;
        m_alu = '0; m_rt = '0; m_tgt = '0; m_wreg = '0; m_frem = 0;
    endtask

    task automatic model_step();
        logic squashing;
        logic taken;
        squashing = (m_frem > 0);
        taken = ev && br && (zero != ne) && !squashing;
        if (squashing) begin
            m_valid = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_m2r = 0; m_pcsrc = 0;
            m_frem = m_frem - 1;
        end else if (!stall) begin
            m_valid = ev;
            m_mr = mr && ev; m_mw = mw && ev; m_rw = rw && ev; m_m2r = m2r && ev;
            m_alu = alu; m_rt = rt; m_wreg = wreg;
            m_pcsrc = taken;
            if (taken) m_tgt = tgt;
            m_frem = taken ? FC : 0;
        end
    endtask

    task automatic check_all();
        chk("valid", o_valid, m_valid);
        chk("mem_read", o_mr, m_mr);
        chk("mem_write", o_mw, m_mw);
        chk("reg_write", o_rw, m_rw);
        chk("mem_to_reg", o_m2r, m_m2r);
        chk("alu_out", o_alu, m_alu);
        chk("rt_data", o_rt, m_rt);
        chk("wreg", o_wreg, m_wreg);
        chk("pc_src", o_pcsrc, m_pcsrc);
        chk("br_target", o_tgt, m_tgt);
        chk("flush", o_flush, m_frem > 0);
`ifdef EXMEM_FWD_EN
        chk("fwd_valid", o_fv, m_valid && m_rw && !m_m2r && (m_wreg != 0));
        chk("fwd_reg", o_freg, m_wreg);
        chk("fwd_data", o_fdata, m_alu);
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #2;
        check_all();
    endtask

    task automatic set_idle();
        ev = 0; zero = 0; br = 0; ne = 0; mr = 0; mw = 0; rw = 0; m2r = 0;
        alu = '0; rt = '0; tgt = '0; wreg = '0;
    endtask

    task automatic rand_in();
        stall = ($urandom_range(0, 3) == 0);
        ev    = ($urandom_range(0, 4) != 0);
        br    = ($urandom_range(0, 2) == 0);
        ne    = 1'($urandom);
        zero  = 1'($urandom);
        mr    = 1'($urandom);
        mw    = 1'($urandom);
        rw    = 1'($urandom);
        m2r   = 1'($urandom);
        alu   = $urandom;
        rt    = $urandom;
        tgt   = $urandom;
        wreg  = AW'($urandom);
    endtask

    task automatic take_beq(input logic [DW-1:0] t);
        set_idle();
        ev = 1; br = 1; zero = 1; ne = 0; tgt = t;
    endtask

    initial begin
        stall = 0;
        set_idle();
        model_reset();
        #12;
        check_all();
        chk("reset_flush", o_flush, 1'b0);
        @(negedge clk);
        rst_n = 1;

        // ALU op into $8
        set_idle(); ev = 1; alu = 32'h7; wreg = 5'd8; rw = 1;
        tick();
        chk("add_alu", o_alu, 32'h7);
        chk("add_wreg", o_wreg, 5'd8);
        chk("add_pcsrc", o_pcsrc, 1'b0);

        // taken beq: one-cycle pc_src, FC-cycle flush
        take_beq(32'h40);
        tick();
        chk("beq_pcsrc", o_pcsrc, 1'b1);
        chk("beq_target", o_tgt, 32'h40);
        chk("beq_flush1", o_flush, 1'b1);
        set_idle();
        tick();
        chk("beq_pcsrc_drop", o_pcsrc, 1'b0);
        chk("beq_flush2", o_flush, 1'b1);
        tick();
        chk("beq_flush_end", o_flush, 1'b0);

        // bne with zero=1 is not taken
        set_idle(); ev = 1; br = 1; ne = 1; zero = 1; tgt = 32'h80;
        tick();
        chk("bne_nt_pcsrc", o_pcsrc, 1'b0);
        chk("bne_nt_flush", o_flush, 1'b0);
        // taken bne arriving during a flush is squashed
        take_beq(32'h100);
        tick();
        set_idle(); ev = 1; br = 1; ne = 1; zero = 0; rw = 1; tgt = 32'h200;
        tick();
        chk("squash_valid", o_valid, 1'b0);
        chk("squash_pcsrc", o_pcsrc, 1'b0);
        chk("squash_target", o_tgt, 32'h100);
        set_idle();
        tick();

        // stall holds MEM contents
        set_idle(); ev = 1; alu = 32'h1234; rw = 1; wreg = 5'd3;
        tick();
        for (int i = 0; i < 3; i++) begin
            rand_in(); stall = 1;
            tick();
            chk("stall_alu", o_alu, 32'h1234);
        end
        stall = 0;
        // flush beats stall
        take_beq(32'h300);
        tick();
        rand_in(); stall = 1; ev = 1;
        tick();
        chk("flush_over_stall", o_valid, 1'b0);
        stall = 0;
        set_idle();
        tick();

        // asynchronous reset in the middle of a flush
        take_beq(32'h400);
        tick();
        @(negedge clk);
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        chk("midflush_rst_flush", o_flush, 1'b0);
        @(negedge clk);
        rst_n = 1;
        set_idle();
        tick();
        chk("post_rst_flush", o_flush, 1'b0);

`ifdef EXMEM_FWD_EN
        set_idle(); ev = 1; rw = 1; wreg = 5'd0; alu = 32'h55;
        tick();
        chk("fwd_r0", o_fv, 1'b0);
        set_idle(); ev = 1; rw = 1; mr = 1; m2r = 1; wreg = 5'd9;
        tick();
        chk("fwd_lw", o_fv, 1'b0);
        set_idle(); ev = 1; rw = 1; wreg = 5'd9; alu = 32'hCAFE_0009;
        tick();
        chk("fwd_add", o_fv, 1'b1);
        chk("fwd_add_data", o_fdata, 32'hCAFE_0009);
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_in();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
